// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with registered result and status flags.
// Single-cycle ops commit at the edge that samples start_i; shifts run on a
// one-bit-per-cycle shifter and commit once the shift counter reaches zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting start_i; non-shift ops commit immediately
// S_SHIFT | shifter running; inputs ignored until the counter drains

module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [7:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] c_o,
  output logic             carry_o,
  output logic             flag_o,
  output logic             low_o,
  output logic             negative_o,
  output logic             zero_o
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    WIDTH_N = CW'(WIDTH);

  localparam logic [7:0] OP_ADD    = 8'd0;
  localparam logic [7:0] OP_ADDU   = 8'd1;
  localparam logic [7:0] OP_ADDI   = 8'd2;
  localparam logic [7:0] OP_ADDUI  = 8'd3;
  localparam logic [7:0] OP_ADDC   = 8'd4;
  localparam logic [7:0] OP_ADDCU  = 8'd5;
  localparam logic [7:0] OP_ADDCUI = 8'd6;
  localparam logic [7:0] OP_ADDCI  = 8'd7;
  localparam logic [7:0] OP_SUB    = 8'd8;
  localparam logic [7:0] OP_SUBI   = 8'd9;
  localparam logic [7:0] OP_CMP    = 8'd10;
  localparam logic [7:0] OP_CMPI   = 8'd11;
  localparam logic [7:0] OP_AND    = 8'd12;
  localparam logic [7:0] OP_OR     = 8'd13;
  localparam logic [7:0] OP_XOR    = 8'd14;
  localparam logic [7:0] OP_NOT    = 8'd15;
  localparam logic [7:0] OP_LSH    = 8'd16;
  localparam logic [7:0] OP_LSHI   = 8'd17;
  localparam logic [7:0] OP_RSH    = 8'd18;
  localparam logic [7:0] OP_RSHI   = 8'd19;
  localparam logic [7:0] OP_ALSH   = 8'd20;
  localparam logic [7:0] OP_ARSH   = 8'd21;
  localparam logic [7:0] OP_NOP    = 8'd22;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  typedef enum logic [1:0] {SH_LEFT, SH_RIGHT, SH_ARITH} sh_mode_t;

  state_t           state_q, state_d;
  sh_mode_t         mode_q, mode_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, flag_q, flag_d, low_q, low_d;
  logic             neg_q, neg_d, zero_q, zero_d;
  logic             done_q, done_d, illegal_q, illegal_d;
  logic             out_q, out_d;   // last bit shifted out
  logic             nz_q, nz_d;     // shift amount was non-zero, so Carry updates

  logic             cin;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff;
  logic [CW-1:0]    n_amt;

  // Shared adder/subtractor and clamped shift amount, all from the sampled inputs.
  assign cin   = (opcode_i inside {OP_ADDC, OP_ADDCU, OP_ADDCUI, OP_ADDCI}) ? carry_q : 1'b0;
  assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
  assign diff  = a_i - b_i;
  assign n_amt = (b_i >= WIDTH_V) ? WIDTH_N : b_i[CW-1:0];

  // Next-state, commit and shifter logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    c_d       = c_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    flag_d    = flag_q;
    low_d     = low_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    out_d     = out_q;
    nz_d      = nz_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d = 1'b1;
          case (opcode_i)
            OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
              c_d    = sum_w[MSB:0];
              flag_d = (a_i[MSB] == b_i[MSB]) && (sum_w[MSB] != a_i[MSB]);
              zero_d = (sum_w[MSB:0] == '0);
            end
            OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
              c_d     = sum_w[MSB:0];
              carry_d = sum_w[WIDTH];
              zero_d  = (sum_w[MSB:0] == '0);
            end
            OP_SUB, OP_SUBI: begin
              c_d     = diff;
              carry_d = (a_i < b_i);
              flag_d  = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
              zero_d  = (diff == '0);
            end
            OP_CMP, OP_CMPI: begin
              low_d  = (a_i < b_i);
              neg_d  = ($signed(a_i) < $signed(b_i));
              zero_d = (a_i == b_i);
            end
            OP_AND: begin
              c_d    = a_i & b_i;
              zero_d = ((a_i & b_i) == '0);
            end
            OP_OR: begin
              c_d    = a_i | b_i;
              zero_d = ((a_i | b_i) == '0);
            end
            OP_XOR: begin
              c_d    = a_i ^ b_i;
              zero_d = ((a_i ^ b_i) == '0);
            end
            OP_NOT: begin
              c_d    = ~a_i;
              zero_d = (~a_i == '0);
            end
            OP_LSH, OP_LSHI, OP_ALSH, OP_RSH, OP_RSHI, OP_ARSH: begin
              done_d  = 1'b0;
              state_d = S_SHIFT;
              sh_d    = a_i;
              cnt_d   = n_amt;
              nz_d    = (n_amt != '0);
              if (opcode_i == OP_ARSH) begin
                mode_d = SH_ARITH;
              end else if (opcode_i == OP_RSH || opcode_i == OP_RSHI) begin
                mode_d = SH_RIGHT;
              end else begin
                mode_d = SH_LEFT;
              end
            end
            OP_NOP: begin
            end
            default: begin
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          case (mode_q)
            SH_LEFT: begin
              out_d = sh_q[MSB];
              sh_d  = {sh_q[MSB-1:0], 1'b0};
            end
            SH_RIGHT: begin
              out_d = sh_q[0];
              sh_d  = {1'b0, sh_q[MSB:1]};
            end
            default: begin
              out_d = sh_q[0];
              sh_d  = {sh_q[MSB], sh_q[MSB:1]};
            end
          endcase
        end else begin
          c_d     = sh_q;
          zero_d  = (sh_q == '0);
          carry_d = nz_q ? out_q : carry_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, result, flag and shifter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mode_q    <= SH_LEFT;
      c_q       <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      flag_q    <= 1'b0;
      low_q     <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      out_q     <= 1'b0;
      nz_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      c_q       <= c_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      flag_q    <= flag_d;
      low_q     <= low_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      out_q     <= out_d;
      nz_q      <= nz_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy_o     = (state_q == S_SHIFT);
  assign done_o     = done_q;
  assign illegal_o  = illegal_q;
  assign c_o        = c_q;
  assign carry_o    = carry_q;
  assign flag_o     = flag_q;
  assign low_o      = low_q;
  assign negative_o = neg_q;
  assign zero_o     = zero_q;

endmodule
